// File: rtl/registrador_deslocamento_param_pkg.sv
// Shared definitions for the parametrised storage/shift register.
//   - Command codes sampled on 'comando' together with 'inicio'.
//   - FSM state encoding. The encoding is one-hot in two bits, so any
//     other value is an unknown state that recovers to OCIOSO.
package registrador_deslocamento_param_pkg;

  localparam logic [2:0] CMD_HOLD   = 3'b000;
  localparam logic [2:0] CMD_LOAD   = 3'b001;
  localparam logic [2:0] CMD_SHL    = 3'b010;
  localparam logic [2:0] CMD_SHR    = 3'b011;
  localparam logic [2:0] CMD_ROL    = 3'b100;
  localparam logic [2:0] CMD_ROR    = 3'b101;
  localparam logic [2:0] CMD_CLEAR  = 3'b110;
  localparam logic [2:0] CMD_INVERT = 3'b111;

  localparam logic [1:0] OCIOSO     = 2'b01;
  localparam logic [1:0] DESLOCANDO = 2'b10;

  // True for the commands that run through the step logic.
  function automatic logic eh_deslocamento(input logic [2:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR) ||
           (cmd == CMD_ROL) || (cmd == CMD_ROR);
  endfunction

endpackage

// File: rtl/registrador_deslocamento_param_passo_deslocamento.sv
// passo_deslocamento: combinational single step of a shift/rotate.
// Ports:
//   i_valor   in  LARGURA  current register value
//   i_comando in  3        SHL/SHR/ROL/ROR; anything else passes i_valor through
//   i_serial  in  1        fill bit for SHL/SHR
//   o_valor   out LARGURA  value after one step
//   o_bit     out 1        bit shifted or rotated out (0 for non-shift codes)
module passo_deslocamento
  import registrador_deslocamento_param_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input  logic [LARGURA-1:0] i_valor,
  input  logic [2:0]         i_comando,
  input  logic               i_serial,
  output logic [LARGURA-1:0] o_valor,
  output logic               o_bit
);

  always_comb begin
    o_valor = i_valor;
    o_bit   = 1'b0;
    case (i_comando)
      CMD_SHL: begin
        o_valor = {i_valor[LARGURA-2:0], i_serial};
        o_bit   = i_valor[LARGURA-1];
      end
      CMD_SHR: begin
        o_valor = {i_serial, i_valor[LARGURA-1:1]};
        o_bit   = i_valor[0];
      end
      CMD_ROL: begin
        o_valor = {i_valor[LARGURA-2:0], i_valor[LARGURA-1]};
        o_bit   = i_valor[LARGURA-1];
      end
      CMD_ROR: begin
        o_valor = {i_valor[0], i_valor[LARGURA-1:1]};
        o_bit   = i_valor[0];
      end
      default: begin
        o_valor = i_valor;
        o_bit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/registrador_deslocamento_param.sv
// registrador_deslocamento_param: parametrised storage/shift register with
// parallel load, clear, invert and multi-step shift/rotate commands.
// Ports:
//   clock          in   1        rising-edge clock
//   reset          in   1        synchronous, active-low
//   inicio         in   1        command request (taken when ocupado=0)
//   comando        in   3        operation code
//   quantidade     in   CW       step count for shift/rotate
//   data           in   LARGURA  parallel load value
//   entrada_serial in   1        fill bit for SHL/SHR, sampled per step
//   saida          out  LARGURA  register contents
//   saida_negada   out  LARGURA  ~saida
//   saida_serial   out  1        last bit shifted/rotated out
//   ocupado        out  1        multi-step command in progress
//   concluido      out  1        one-cycle pulse when a command finishes
module registrador_deslocamento_param
  import registrador_deslocamento_param_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int CW      = $clog2(LARGURA) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [2:0]         comando,
  input  logic [CW-1:0]      quantidade,
  input  logic [LARGURA-1:0] data,
  input  logic               entrada_serial,
  output logic [LARGURA-1:0] saida,
  output logic [LARGURA-1:0] saida_negada,
  output logic               saida_serial,
  output logic               ocupado,
  output logic               concluido
);

  logic [LARGURA-1:0] r_saida;
  logic               r_serial;
  logic               r_concluido;
  logic [1:0]         r_estado;
  logic [CW-1:0]      r_contador;
  logic [2:0]         r_cmd;

  logic [2:0]         w_cmd_passo;
  logic [LARGURA-1:0] w_passo;
  logic               w_bit;

  // Step 1 uses the live command at the accept edge; later steps use the
  // command latched at accept so the inputs may change while busy.
  assign w_cmd_passo = (r_estado == DESLOCANDO) ? r_cmd : comando;

  passo_deslocamento #(.LARGURA(LARGURA)) u_passo (
    .i_valor   (r_saida),
    .i_comando (w_cmd_passo),
    .i_serial  (entrada_serial),
    .o_valor   (w_passo),
    .o_bit     (w_bit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_saida     <= '0;
      r_serial    <= 1'b0;
      r_concluido <= 1'b0;
      r_estado    <= OCIOSO;
      r_contador  <= '0;
      r_cmd       <= CMD_HOLD;
    end else begin
      r_concluido <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (inicio) begin
            case (comando)
              CMD_LOAD:   begin r_saida <= data;     r_concluido <= 1'b1; end
              CMD_CLEAR:  begin r_saida <= '0;       r_concluido <= 1'b1; end
              CMD_INVERT: begin r_saida <= ~r_saida; r_concluido <= 1'b1; end
              CMD_SHL, CMD_SHR, CMD_ROL, CMD_ROR: begin
                if (quantidade == '0) begin
                  r_concluido <= 1'b1;
                end else begin
                  r_saida  <= w_passo;
                  r_serial <= w_bit;
                  if (quantidade == CW'(1)) begin
                    r_concluido <= 1'b1;
                  end else begin
                    r_estado   <= DESLOCANDO;
                    r_contador <= quantidade - CW'(1);
                    r_cmd      <= comando;
                  end
                end
              end
              default:    r_concluido <= 1'b1;  // HOLD
            endcase
          end
        end
        DESLOCANDO: begin
          // inicio is ignored here; only the latched command advances.
          r_saida    <= w_passo;
          r_serial   <= w_bit;
          r_contador <= r_contador - CW'(1);
          if (r_contador == CW'(1)) begin
            r_estado    <= OCIOSO;
            r_concluido <= 1'b1;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign saida        = r_saida;
  assign saida_negada = ~r_saida;
  assign saida_serial = r_serial;
  assign ocupado      = (r_estado == DESLOCANDO);
  assign concluido    = r_concluido;

endmodule
